// File: rtl/avsdpll_ctrl_pkg.sv
// Shared types and default constants for the avsdpll power-up / lock controller.
package avsdpll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_CP_ON   = 3'd1,
    ST_VCO_ON  = 3'd2,
    ST_ACQUIRE = 3'd3,
    ST_LOCKED  = 3'd4,
    ST_FAULT   = 3'd5,
    ST_DRAIN   = 3'd6
  } state_t;

  localparam int unsigned PLL_RATIO       = 8;
  localparam int unsigned PLL_DIV         = 16;
  localparam int unsigned CP_DLY_DEF      = 16;
  localparam int unsigned SETTLE_CYC_DEF  = 64;
  localparam int unsigned WIN_CYC_DEF     = 256;
  localparam int unsigned EXP_CNT_DEF     = WIN_CYC_DEF * PLL_RATIO / PLL_DIV;
  localparam int unsigned TOL_DEF         = 2;
  localparam int unsigned LOCK_HITS_DEF   = 3;
  localparam int unsigned LOSS_MISSES_DEF = 2;
  localparam int unsigned MAX_WIN_DEF     = 32;
  localparam int unsigned CNT_W_DEF       = 12;

endpackage

// File: rtl/avsdpll_freq_meter.sv
// Frequency meter: synchronises the PLL-domain divided toggle, counts its
// edges over a fixed REF window and flags whether the count is in tolerance.
// Optional macro AVSDPLL_CTRL_STATUS_EN adds the cnt output (last window count).
module avsdpll_freq_meter
  import avsdpll_ctrl_pkg::*;
#(
  parameter int unsigned WIN_CYC = WIN_CYC_DEF,
  parameter int unsigned EXP_CNT = EXP_CNT_DEF,
  parameter int unsigned TOL     = TOL_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             tog,
  output logic             window_done,
  output logic             good
`ifdef AVSDPLL_CTRL_STATUS_EN
  , output logic [CNT_W-1:0] cnt
`endif
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIN_CYC - 1);
  localparam logic [CNT_W-1:0] C_EXP  = CNT_W'(EXP_CNT);
  localparam logic [CNT_W-1:0] C_TOL  = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] C_MAX  = '1;

  logic [1:0]       r_sync;
  logic             r_tog_d;
  logic [CNT_W-1:0] r_win;
  logic [CNT_W-1:0] r_edge;
  logic             w_edge;
  logic             w_term;
  logic             w_good;
  logic [CNT_W-1:0] w_total;
  logic [CNT_W-1:0] w_diff;

  // An edge seen on the terminal cycle is folded into the closing window.
  assign w_edge  = r_sync[1] ^ r_tog_d;
  assign w_total = (w_edge && (r_edge != C_MAX)) ? r_edge + 1'b1 : r_edge;
  assign w_diff  = (w_total >= C_EXP) ? w_total - C_EXP : C_EXP - w_total;
  assign w_term  = (r_win == C_LAST);
  assign w_good  = (w_total != C_MAX) && (w_diff <= C_TOL);

  // Two-flop synchroniser plus delay flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_tog_d <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], tog};
      r_tog_d <= r_sync[1];
    end
  end

  // Window and edge counters; strobes are registered at the window close.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win       <= '0;
      r_edge      <= '0;
      window_done <= 1'b0;
      good        <= 1'b0;
    end else if (!en) begin
      r_win       <= '0;
      r_edge      <= '0;
      window_done <= 1'b0;
      good        <= 1'b0;
    end else begin
      window_done <= w_term;
      good        <= w_term && w_good;
      if (w_term) begin
        r_win  <= '0;
        r_edge <= '0;
      end else begin
        r_win  <= r_win + 1'b1;
        r_edge <= w_total;
      end
    end
  end

`ifdef AVSDPLL_CTRL_STATUS_EN
  // Capture the count of each completed window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && w_term) begin
      cnt <= w_total;
    end
  end
`endif

endmodule

// File: rtl/avsdpll_ctrl.sv
// avsdpll power-up sequencer and lock monitor (REF clock domain).
// Optional macro AVSDPLL_CTRL_STATUS_EN adds meas_cnt and state_o status ports.
module avsdpll_ctrl
  import avsdpll_ctrl_pkg::*;
#(
  parameter int unsigned CP_DLY      = CP_DLY_DEF,
  parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int unsigned WIN_CYC     = WIN_CYC_DEF,
  parameter int unsigned EXP_CNT     = EXP_CNT_DEF,
  parameter int unsigned TOL         = TOL_DEF,
  parameter int unsigned LOCK_HITS   = LOCK_HITS_DEF,
  parameter int unsigned LOSS_MISSES = LOSS_MISSES_DEF,
  parameter int unsigned MAX_WIN     = MAX_WIN_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en,
  input  logic pll_div_tog,
  output logic ENb_CP,
  output logic ENb_VCO,
  output logic clk_sel,
  output logic pll_locked,
  output logic fault,
  output logic lock_lost
`ifdef AVSDPLL_CTRL_STATUS_EN
  , output logic [CNT_W-1:0] meas_cnt
  , output logic [2:0]       state_o
`endif
);

  localparam logic [15:0] C_CP_LAST     = 16'(CP_DLY - 1);
  localparam logic [15:0] C_SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [7:0]  C_HITS_LAST   = 8'(LOCK_HITS - 1);
  localparam logic [7:0]  C_MISS_LAST   = 8'(LOSS_MISSES - 1);
  localparam logic [7:0]  C_WIN_LAST    = 8'(MAX_WIN - 1);

  state_t      r_state, w_next;
  logic [15:0] r_dly, w_dly;
  logic [7:0]  r_hits, w_hits;
  logic [7:0]  r_wins, w_wins;
  logic [7:0]  r_miss, w_miss;
  logic        r_cp, r_vco, r_sel, r_lock, r_fault, r_lost;
  logic        w_cp, w_vco, w_sel, w_lock, w_fault, w_lost;
  logic        w_meas_en, w_done, w_good;

  assign w_meas_en = (r_state == ST_ACQUIRE) || (r_state == ST_LOCKED);

  avsdpll_freq_meter #(
    .WIN_CYC (WIN_CYC),
    .EXP_CNT (EXP_CNT),
    .TOL     (TOL),
    .CNT_W   (CNT_W)
  ) u_meter (
    .clk         (CLK),
    .rst_n       (RST_N),
    .en          (w_meas_en),
    .tog         (pll_div_tog),
    .window_done (w_done),
    .good        (w_good)
`ifdef AVSDPLL_CTRL_STATUS_EN
    , .cnt       (meas_cnt)
`endif
  );

  // Next state, counters and next output values (outputs follow next state
  // so every output is a plain register).
  always_comb begin
    w_next = r_state;
    w_dly  = r_dly;
    w_hits = r_hits;
    w_wins = r_wins;
    w_miss = r_miss;
    w_lost = 1'b0;
    case (r_state)
      ST_OFF: begin
        if (en) begin
          w_next = ST_CP_ON;
          w_dly  = '0;
        end
      end
      ST_CP_ON: begin
        if (r_dly == C_CP_LAST) begin
          w_next = ST_VCO_ON;
          w_dly  = '0;
        end else begin
          w_dly = r_dly + 1'b1;
        end
      end
      ST_VCO_ON: begin
        if (r_dly == C_SETTLE_LAST) begin
          w_next = ST_ACQUIRE;
          w_hits = '0;
          w_wins = '0;
          w_miss = '0;
        end else begin
          w_dly = r_dly + 1'b1;
        end
      end
      ST_ACQUIRE: begin
        if (w_done) begin
          w_wins = r_wins + 1'b1;
          w_hits = w_good ? r_hits + 1'b1 : '0;
          if (w_good && (r_hits == C_HITS_LAST)) begin
            w_next = ST_LOCKED;
            w_miss = '0;
          end else if (r_wins == C_WIN_LAST) begin
            w_next = ST_FAULT;
          end
        end
      end
      ST_LOCKED: begin
        if (w_done) begin
          if (w_good) begin
            w_miss = '0;
          end else if (r_miss == C_MISS_LAST) begin
            w_next = ST_ACQUIRE;
            w_lost = 1'b1;
            w_hits = '0;
            w_wins = '0;
            w_miss = '0;
          end else begin
            w_miss = r_miss + 1'b1;
          end
        end
      end
      ST_FAULT: begin
        if (!en) w_next = ST_OFF;
      end
      ST_DRAIN: w_next = ST_OFF;
      default:  w_next = ST_OFF;
    endcase

    // Dropping en always passes through DRAIN so the mux leaves the PLL
    // clock one cycle before the enables fall.
    if (!en && (r_state inside {ST_CP_ON, ST_VCO_ON, ST_ACQUIRE, ST_LOCKED})) begin
      w_next = ST_DRAIN;
      w_lost = 1'b0;
    end

    w_cp    = 1'b0;
    w_vco   = 1'b0;
    w_sel   = 1'b0;
    w_lock  = 1'b0;
    w_fault = 1'b0;
    case (w_next)
      ST_CP_ON:              w_cp = 1'b1;
      ST_VCO_ON, ST_ACQUIRE: begin w_cp = 1'b1; w_vco = 1'b1; end
      ST_LOCKED: begin
        w_cp   = 1'b1;
        w_vco  = 1'b1;
        w_sel  = 1'b1;
        w_lock = 1'b1;
      end
      ST_FAULT:              w_fault = 1'b1;
      ST_DRAIN:              begin w_cp = r_cp; w_vco = r_vco; end
      default:               ;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_OFF;
      r_dly   <= '0;
      r_hits  <= '0;
      r_wins  <= '0;
      r_miss  <= '0;
      r_cp    <= 1'b0;
      r_vco   <= 1'b0;
      r_sel   <= 1'b0;
      r_lock  <= 1'b0;
      r_fault <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_dly   <= w_dly;
      r_hits  <= w_hits;
      r_wins  <= w_wins;
      r_miss  <= w_miss;
      r_cp    <= w_cp;
      r_vco   <= w_vco;
      r_sel   <= w_sel;
      r_lock  <= w_lock;
      r_fault <= w_fault;
      r_lost  <= w_lost;
    end
  end

  assign ENb_CP     = r_cp;
  assign ENb_VCO    = r_vco;
  assign clk_sel    = r_sel;
  assign pll_locked = r_lock;
  assign fault      = r_fault;
  assign lock_lost  = r_lost;
`ifdef AVSDPLL_CTRL_STATUS_EN
  assign state_o    = r_state;
`endif

endmodule

// File: tb/tb_avsdpll_ctrl.sv
// Directed self-checking bench for avsdpll_ctrl.
// Output vector order: {ENb_CP, ENb_VCO, clk_sel, pll_locked, fault, lock_lost}.
module tb_avsdpll_ctrl;

  logic CLK = 1'b0;
  logic RST_N;
  logic en;
  logic pll_div_tog;
  logic ENb_CP, ENb_VCO, clk_sel, pll_locked, fault, lock_lost;
`ifdef AVSDPLL_CTRL_STATUS_EN
  logic [11:0] meas_cnt;
  logic [2:0]  state_o;
`endif
  logic [5:0] outs;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          tog_n = 128;  // toggle flips per 256-cycle period
  int          ph    = 0;

  assign outs = {ENb_CP, ENb_VCO, clk_sel, pll_locked, fault, lock_lost};

  avsdpll_ctrl dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .en          (en),
    .pll_div_tog (pll_div_tog),
    .ENb_CP      (ENb_CP),
    .ENb_VCO     (ENb_VCO),
    .clk_sel     (clk_sel),
    .pll_locked  (pll_locked),
    .fault       (fault),
    .lock_lost   (lock_lost)
`ifdef AVSDPLL_CTRL_STATUS_EN
    , .meas_cnt  (meas_cnt)
    , .state_o   (state_o)
`endif
  );

  initial forever #5 CLK = ~CLK;

  // Periodic toggle pattern: flips on even phases (every 2 CLK) for the first
  // min(N,128) slots, plus odd phases for counts above 128.
  initial begin
    pll_div_tog = 1'b0;
    forever begin
      @(negedge CLK);
      if (((ph % 2 == 0) && (ph / 2 < tog_n)) ||
          ((ph % 2 == 1) && (tog_n > 128) && (ph / 2 < tog_n - 128)))
        pll_div_tog = ~pll_div_tog;
      ph = (ph + 1) % 256;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    tick(2);
    n_cmp++;
    if (outs !== 6'b000000) begin n_err++; $display("FAIL reset_hold: got %b want %b", outs, 6'b000000); end
    @(negedge CLK);
    RST_N = 1'b1;
    tick(3);
    n_cmp++;
    if (outs !== 6'b000000) begin n_err++; $display("FAIL reset_off: got %b want %b", outs, 6'b000000); end
  endtask

  task automatic test_power_up;
    en = 1'b1;
    tick(1);
    n_cmp++;
    if (outs !== 6'b100000) begin n_err++; $display("FAIL cp_rise: got %b want %b", outs, 6'b100000); end
    tick(15);
    n_cmp++;
    if (outs !== 6'b100000) begin n_err++; $display("FAIL vco_early: got %b want %b", outs, 6'b100000); end
    tick(1);
    n_cmp++;
    if (outs !== 6'b110000) begin n_err++; $display("FAIL vco_rise: got %b want %b", outs, 6'b110000); end
    tick(832);
    n_cmp++;
    if (outs !== 6'b110000) begin n_err++; $display("FAIL lock_early: got %b want %b", outs, 6'b110000); end
    tick(1);
    n_cmp++;
    if (outs !== 6'b111100) begin n_err++; $display("FAIL lock_rise: got %b want %b", outs, 6'b111100); end
  endtask

  task automatic test_loss_relock;
    tog_n = 0;
    tick(511);
    n_cmp++;
    if (outs !== 6'b111100) begin n_err++; $display("FAIL loss_early: got %b want %b", outs, 6'b111100); end
    tick(1);
    n_cmp++;
    if (outs !== 6'b110001) begin n_err++; $display("FAIL lock_lost_pulse: got %b want %b", outs, 6'b110001); end
    tick(1);
    n_cmp++;
    if (outs !== 6'b110000) begin n_err++; $display("FAIL lock_lost_single: got %b want %b", outs, 6'b110000); end
    tick(99);
    tog_n = 128;
    tick(923);
    n_cmp++;
    if (outs !== 6'b110000) begin n_err++; $display("FAIL relock_early: got %b want %b", outs, 6'b110000); end
    tick(1);
    n_cmp++;
    if (outs !== 6'b111100) begin n_err++; $display("FAIL relock: got %b want %b", outs, 6'b111100); end
  endtask

  task automatic test_drain;
    en = 1'b0;
    tick(1);
    n_cmp++;
    if (outs !== 6'b110000) begin n_err++; $display("FAIL drain: got %b want %b", outs, 6'b110000); end
    en = 1'b1;
    tick(1);
    n_cmp++;
    if (outs !== 6'b000000) begin n_err++; $display("FAIL drain_en_ignored: got %b want %b", outs, 6'b000000); end
    tick(1);
    n_cmp++;
    if (outs !== 6'b100000) begin n_err++; $display("FAIL restart_from_off: got %b want %b", outs, 6'b100000); end
    en = 1'b0;
    tick(1);
    n_cmp++;
    if (outs !== 6'b100000) begin n_err++; $display("FAIL drain_cp_only: got %b want %b", outs, 6'b100000); end
    tick(1);
    n_cmp++;
    if (outs !== 6'b000000) begin n_err++; $display("FAIL drain_off: got %b want %b", outs, 6'b000000); end
  endtask

  task automatic test_async_reset;
    en = 1'b1;
    tick(200);
    n_cmp++;
    if (outs !== 6'b110000) begin n_err++; $display("FAIL acq_before_rst: got %b want %b", outs, 6'b110000); end
    #3;
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if (outs !== 6'b000000) begin n_err++; $display("FAIL async_rst: got %b want %b", outs, 6'b000000); end
    tick(2);
    @(negedge CLK);
    RST_N = 1'b1;
    tick(1);
    n_cmp++;
    if (outs !== 6'b100000) begin n_err++; $display("FAIL rst_restart_cp: got %b want %b", outs, 6'b100000); end
    tick(15);
    n_cmp++;
    if (outs !== 6'b100000) begin n_err++; $display("FAIL rst_vco_early: got %b want %b", outs, 6'b100000); end
    tick(1);
    n_cmp++;
    if (outs !== 6'b110000) begin n_err++; $display("FAIL rst_restart_vco: got %b want %b", outs, 6'b110000); end
    en = 1'b0;
    tick(2);
    n_cmp++;
    if (outs !== 6'b000000) begin n_err++; $display("FAIL rst_seq_off: got %b want %b", outs, 6'b000000); end
  endtask

  task automatic test_tolerance;
    int   ncase[4];
    logic goodc[4];
    logic [5:0] exp_o;
    ncase[0] = 126; goodc[0] = 1'b1;
    ncase[1] = 130; goodc[1] = 1'b1;
    ncase[2] = 125; goodc[2] = 1'b0;
    ncase[3] = 131; goodc[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tog_n = ncase[i];
      tick(300);
      en = 1'b1;
      tick(850);
      exp_o = goodc[i] ? 6'b111100 : 6'b110000;
      n_cmp++;
      if (outs !== exp_o) begin n_err++; $display("FAIL tol_%0d: got %b want %b", ncase[i], outs, exp_o); end
`ifdef AVSDPLL_CTRL_STATUS_EN
      n_cmp++;
      if (meas_cnt !== 12'(ncase[i])) begin n_err++; $display("FAIL meas_cnt_%0d: got %0d want %0d", ncase[i], meas_cnt, ncase[i]); end
      n_cmp++;
      if (state_o !== (goodc[i] ? 3'd4 : 3'd3)) begin n_err++; $display("FAIL state_o_%0d: got %0d want %0d", ncase[i], state_o, goodc[i] ? 4 : 3); end
`endif
      en = 1'b0;
      tick(2);
      n_cmp++;
      if (outs !== 6'b000000) begin n_err++; $display("FAIL tol_off_%0d: got %b want %b", ncase[i], outs, 6'b000000); end
    end
  endtask

  task automatic test_fault;
    tog_n = 131;
    tick(300);
    en = 1'b1;
    tick(8273);
    n_cmp++;
    if (outs !== 6'b110000) begin n_err++; $display("FAIL fault_early: got %b want %b", outs, 6'b110000); end
    tick(1);
    n_cmp++;
    if (outs !== 6'b000010) begin n_err++; $display("FAIL fault_set: got %b want %b", outs, 6'b000010); end
    tick(5);
    n_cmp++;
    if (outs !== 6'b000010) begin n_err++; $display("FAIL fault_sticky: got %b want %b", outs, 6'b000010); end
    en = 1'b0;
    tick(1);
    n_cmp++;
    if (outs !== 6'b000000) begin n_err++; $display("FAIL fault_exit: got %b want %b", outs, 6'b000000); end
  endtask

  initial begin
    RST_N = 1'b0;
    en    = 1'b0;
    test_reset();
    test_power_up();
    test_loss_relock();
    test_drain();
    test_async_reset();
    test_tolerance();
    test_fault();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
